controle_escrita_banco: RTL

Write-back controller for the register file of the multicycle CPU. It sits between the write-back requesters and the register-address mux, and buffers one pending write per requester. It arbitrates the single register-file write port and drives the mux select (`RegWriteMUX`), the field copies the mux consumes, the write data and `RegWrite`. Instructions that need two writes, such as pop (`rt` plus `$29`), are serialized in a defined order.

---
 rtl/controle_escrita_banco_pkg.sv | 32 +++
 rtl/controle_escrita_banco_slot_escrita.sv | 61 ++++++
 rtl/controle_escrita_banco.sv | 112 +++++++++++
 3 files changed

// File: rtl/controle_escrita_banco_pkg.sv
// Shared constants for the register-file write-back controller: mux select
// encodings, requester indices and the default age threshold.
package controle_escrita_banco_pkg;

  localparam logic [1:0] SEL_RT = 2'b00;
  localparam logic [1:0] SEL_29 = 2'b01;
  localparam logic [1:0] SEL_31 = 2'b10;
  localparam logic [1:0] SEL_RD = 2'b11;

  // Lower index means higher fixed priority.
  localparam logic [1:0] IDX_SP   = 2'd0;
  localparam logic [1:0] IDX_LINK = 2'd1;
  localparam logic [1:0] IDX_ALU  = 2'd2;
  localparam logic [1:0] IDX_LOAD = 2'd3;
  localparam int         N_REQ    = 4;

  localparam int IDADE_MAX = 3;

  typedef logic [1:0] idade_t;

  function automatic logic [1:0] sel_de(input logic [1:0] idx);
    logic [1:0] sel;
    case (idx)
      IDX_SP:   sel = SEL_29;
      IDX_LINK: sel = SEL_31;
      IDX_ALU:  sel = SEL_RD;
      default:  sel = SEL_RT;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/controle_escrita_banco_slot_escrita.sv
// One buffered write request: pending flag, data, optional register field and
// a saturating age counter used by the arbiter to avoid starvation.
module slot_escrita
  import controle_escrita_banco_pkg::*;
#(
  parameter int LARG_DADO = 32,
  parameter bit TEM_CAMPO = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 flush,
  input  logic                 concedido,
  input  logic [LARG_DADO-1:0] dado,
  input  logic [4:0]           campo,
  output logic                 pend,
  output logic [LARG_DADO-1:0] dado_q,
  output logic [4:0]           campo_q,
  output idade_t               idade
);

  logic aceita;

  // Ready is !pend, so an accept can never coincide with this slot's grant.
  assign aceita = req & ~pend & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend   <= 1'b0;
      dado_q <= '0;
      idade  <= '0;
    end else if (flush) begin
      pend  <= 1'b0;
      idade <= '0;
    end else if (aceita) begin
      pend   <= 1'b1;
      dado_q <= dado;
      idade  <= '0;
    end else if (pend) begin
      if (concedido) begin
        pend  <= 1'b0;
        idade <= '0;
      end else if (idade != 2'b11) begin
        idade <= idade + 2'd1;
      end
    end
  end

  if (TEM_CAMPO) begin : g_campo
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        campo_q <= '0;
      end else if (aceita) begin
        campo_q <= campo;
      end
    end
  end else begin : g_sem_campo
    assign campo_q = '0;
  end

endmodule

// File: rtl/controle_escrita_banco.sv
// Write-back controller: four single-entry request slots sharing the one
// register-file write port, with age-promoted fixed-priority arbitration.
module controle_escrita_banco #(
  parameter int LARG_DADO = 32,
  parameter int IDADE_MAX = controle_escrita_banco_pkg::IDADE_MAX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_sp,
  input  logic                 req_link,
  input  logic                 req_alu,
  input  logic                 req_load,
  output logic                 pronto_sp,
  output logic                 pronto_link,
  output logic                 pronto_alu,
  output logic                 pronto_load,
  input  logic [LARG_DADO-1:0] dado_sp,
  input  logic [LARG_DADO-1:0] dado_link,
  input  logic [LARG_DADO-1:0] dado_alu,
  input  logic [LARG_DADO-1:0] dado_load,
  input  logic [4:0]           campo_rd,
  input  logic [4:0]           campo_rt,
  input  logic                 flush,
  output logic [1:0]           RegWriteMUX,
  output logic [4:0]           rt_out,
  output logic [15:0]          imm_out,
  output logic                 RegWrite,
  output logic [LARG_DADO-1:0] dado_escrita,
  output logic                 ocupado
);

  import controle_escrita_banco_pkg::*;

  localparam idade_t LIMIAR = idade_t'(IDADE_MAX);

  logic [N_REQ-1:0]     req_v;
  logic [N_REQ-1:0]     pend;
  logic [N_REQ-1:0]     concede;
  logic [N_REQ-1:0]     envelhecido;
  logic [N_REQ-1:0]     candidatos;
  logic [1:0]           vencedor;
  logic [LARG_DADO-1:0] dado_in [N_REQ];
  logic [LARG_DADO-1:0] dado_q  [N_REQ];
  logic [4:0]           campo_in[N_REQ];
  logic [4:0]           campo_q [N_REQ];
  idade_t               idade   [N_REQ];

  assign req_v = {req_load, req_alu, req_link, req_sp};

  assign dado_in[IDX_SP]   = dado_sp;
  assign dado_in[IDX_LINK] = dado_link;
  assign dado_in[IDX_ALU]  = dado_alu;
  assign dado_in[IDX_LOAD] = dado_load;

  assign campo_in[IDX_SP]   = '0;
  assign campo_in[IDX_LINK] = '0;
  assign campo_in[IDX_ALU]  = campo_rd;
  assign campo_in[IDX_LOAD] = campo_rt;

  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    slot_escrita #(
      .LARG_DADO (LARG_DADO),
      .TEM_CAMPO ((i == int'(IDX_ALU)) || (i == int'(IDX_LOAD)))
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .req       (req_v[i]),
      .flush     (flush),
      .concedido (concede[i]),
      .dado      (dado_in[i]),
      .campo     (campo_in[i]),
      .pend      (pend[i]),
      .dado_q    (dado_q[i]),
      .campo_q   (campo_q[i]),
      .idade     (idade[i])
    );
  end

  // Aged slots form the candidate set when any exist; fixed priority then
  // picks the lowest index, so ties among aged slots resolve the same way.
  always_comb begin
    envelhecido = '0;
    for (int i = 0; i < N_REQ; i++) begin
      envelhecido[i] = pend[i] && (idade[i] >= LIMIAR);
    end
    candidatos = (|envelhecido) ? envelhecido : pend;
    vencedor   = IDX_SP;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (candidatos[i]) begin
        vencedor = 2'(i);
      end
    end
    concede = '0;
    if (|candidatos) begin
      concede[vencedor] = 1'b1;
    end
  end

  assign RegWrite     = |candidatos;
  assign RegWriteMUX  = RegWrite ? sel_de(vencedor) : SEL_RT;
  assign dado_escrita = RegWrite ? dado_q[vencedor] : '0;

  assign rt_out  = campo_q[IDX_LOAD];
  assign imm_out = {campo_q[IDX_ALU], 11'b0};
  assign ocupado = |pend;

  assign pronto_sp   = ~pend[IDX_SP];
  assign pronto_link = ~pend[IDX_LINK];
  assign pronto_alu  = ~pend[IDX_ALU];
  assign pronto_load = ~pend[IDX_LOAD];

endmodule
